// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, 16-op ALU, multi-cycle MUL/DIV unit with HI/LO, and the EX/MEM register.
// Optional feature macro: MD_UNIT_EN (MD unit, HI/LO and ops 8-15 live only when defined).
module ex_stage_md #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [31:0]      e_instruc,
    input  logic [3:0]       e_alu_op,
    input  logic             e_alu_src,
    input  logic [WIDTH-1:0] e_rd1,
    input  logic [WIDTH-1:0] e_rd2,
    input  logic [WIDTH-1:0] e_ext,
    input  logic [WIDTH-1:0] e_pc,
    input  logic [WIDTH-1:0] e_m_pass,
    input  logic [WIDTH-1:0] e_w_wrd,
    input  logic [1:0]       pass_src_a,
    input  logic [1:0]       pass_src_b,
    input  logic [4:0]       e_wra,
    input  logic             flush,
    output logic             md_stall,
    output logic             md_busy,
    output logic             em_valid,
    output logic [31:0]      em_instruc,
    output logic [WIDTH-1:0] em_alu_re,
    output logic [WIDTH-1:0] em_wtdm,
    output logic [WIDTH-1:0] em_pc,
    output logic [4:0]       em_wra
);

    localparam logic [WIDTH-1:0] LUI_MASK = WIDTH'(32'hFFFF_FFFF);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_LUI  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;
    localparam logic [3:0] OP_MTHI = 4'd14;
    localparam logic [3:0] OP_MTLO = 4'd15;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] rtf;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             md_op;
    logic             accept;

    // Forwarding selection for A and for the rt value (store data / B source)
    always_comb begin
        op_a = '0;
        unique case (pass_src_a)
            2'b00:   op_a = e_rd1;
            2'b01:   op_a = e_m_pass;
            2'b10:   op_a = e_w_wrd;
            default: op_a = '0;
        endcase
        rtf = '0;
        unique case (pass_src_b)
            2'b00:   rtf = e_rd2;
            2'b01:   rtf = e_m_pass;
            2'b10:   rtf = e_w_wrd;
            default: rtf = '0;
        endcase
    end

    assign op_b   = e_alu_src ? e_ext : rtf;
    assign md_op  = e_alu_op[3];
    assign accept = e_valid & ~flush & ~md_stall;

`ifdef MD_UNIT_EN
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               start;

    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        a_zx;
    logic [2*WIDTH-1:0]        b_zx;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      div_zero;
    logic                      div_ovf;
    logic [WIDTH-1:0]          b_safe_s;
    logic [WIDTH-1:0]          b_safe_u;
    logic [WIDTH-1:0]          q_s;
    logic [WIDTH-1:0]          r_s;
    logic [WIDTH-1:0]          q_u;
    logic [WIDTH-1:0]          r_u;
    logic [2*WIDTH-1:0]        md_res;

    assign start    = accept & md_op & ~e_alu_op[2];
    assign md_busy  = busy_q;
    assign md_stall = e_valid & md_op & busy_q & ~flush;

    assign a_sx   = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    assign b_sx   = {{WIDTH{op_b[WIDTH-1]}}, op_b};
    assign prod_s = a_sx * b_sx;
    assign a_zx   = {{WIDTH{1'b0}}, op_a};
    assign b_zx   = {{WIDTH{1'b0}}, op_b};
    assign prod_u = a_zx * b_zx;

    // Corner cases are patched after the divide, so the divisor is forced to 1 there
    assign div_zero = (op_b == '0);
    assign div_ovf  = (op_a == SMIN) && (op_b == '1);
    assign b_safe_s = (div_zero || div_ovf) ? WIDTH'(1) : op_b;
    assign b_safe_u = div_zero ? WIDTH'(1) : op_b;
    assign q_s      = $signed(op_a) / $signed(b_safe_s);
    assign r_s      = $signed(op_a) % $signed(b_safe_s);
    assign q_u      = op_a / b_safe_u;
    assign r_u      = op_a % b_safe_u;

    always_comb begin
        md_res = '0;
        unique case (e_alu_op[1:0])
            2'b00: md_res = prod_s;
            2'b01: md_res = prod_u;
            2'b10: begin
                if (div_zero)     md_res = {op_a, {WIDTH{1'b1}}};
                else if (div_ovf) md_res = {{WIDTH{1'b0}}, SMIN};
                else              md_res = {r_s, q_s};
            end
            default: begin
                if (div_zero) md_res = {op_a, {WIDTH{1'b1}}};
                else          md_res = {r_u, q_u};
            end
        endcase
    end

    // MD sequencer: result is latched at start and committed to HI/LO when the count expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= md_res[2*WIDTH-1:WIDTH];
                        pend_lo <= md_res[WIDTH-1:0];
                        cnt     <= e_alu_op[1] ? DIV_CNT : MUL_CNT;
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi     <= pend_hi;
                        lo     <= pend_lo;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // MTHI/MTLO only accept while idle, so they never collide with a commit
            if (accept && (e_alu_op == OP_MTHI)) hi <= op_a;
            if (accept && (e_alu_op == OP_MTLO)) lo <= op_a;
        end
    end
`else
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    // ALU result; MD control ops return 0, the move ops return their HI/LO/A value
    always_comb begin
        alu_res = '0;
        case (e_alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_LUI:  alu_res = (op_b << 16) & LUI_MASK;
            OP_AND:  alu_res = op_a & op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
            OP_SLTU: alu_res = (op_a < op_b) ? WIDTH'(1) : '0;
`ifdef MD_UNIT_EN
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MTHI: alu_res = op_a;
            OP_MTLO: alu_res = op_a;
`endif
            default: alu_res = '0;
        endcase
    end

    // EX/MEM register: load on accept, bubble otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em_valid   <= 1'b0;
            em_instruc <= '0;
            em_alu_re  <= '0;
            em_wtdm    <= '0;
            em_pc      <= '0;
            em_wra     <= '0;
        end else if (accept) begin
            em_valid   <= 1'b1;
            em_instruc <= e_instruc;
            em_alu_re  <= alu_res;
            em_wtdm    <= rtf;
            em_pc      <= e_pc;
            em_wra     <= e_wra;
        end else begin
            em_valid   <= 1'b0;
            em_instruc <= '0;
            em_alu_re  <= '0;
            em_wtdm    <= '0;
            em_pc      <= '0;
            em_wra     <= '0;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md; MD scenarios are exercised when MD_UNIT_EN is defined.
module tb_ex_stage_md;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             e_valid = 1'b0;
    logic [31:0]      e_instruc = '0;
    logic [3:0]       e_alu_op = '0;
    logic             e_alu_src = 1'b0;
    logic [WIDTH-1:0] e_rd1 = '0, e_rd2 = '0, e_ext = '0, e_pc = '0;
    logic [WIDTH-1:0] e_m_pass = '0, e_w_wrd = '0;
    logic [1:0]       pass_src_a = '0, pass_src_b = '0;
    logic [4:0]       e_wra = '0;
    logic             flush = 1'b0;
    logic             md_stall, md_busy, em_valid;
    logic [31:0]      em_instruc;
    logic [WIDTH-1:0] em_alu_re, em_wtdm, em_pc;
    logic [4:0]       em_wra;

    int checks = 0;
    int errors = 0;

    ex_stage_md #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_instruc(e_instruc),
        .e_alu_op(e_alu_op), .e_alu_src(e_alu_src), .e_rd1(e_rd1), .e_rd2(e_rd2),
        .e_ext(e_ext), .e_pc(e_pc), .e_m_pass(e_m_pass), .e_w_wrd(e_w_wrd),
        .pass_src_a(pass_src_a), .pass_src_b(pass_src_b), .e_wra(e_wra), .flush(flush),
        .md_stall(md_stall), .md_busy(md_busy), .em_valid(em_valid), .em_instruc(em_instruc),
        .em_alu_re(em_alu_re), .em_wtdm(em_wtdm), .em_pc(em_pc), .em_wra(em_wra)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        e_valid    = 1'b1;
        flush      = 1'b0;
        e_alu_op   = op;
        pass_src_a = 2'b00;
        pass_src_b = 2'b00;
        e_alu_src  = 1'b1;
        e_rd1      = a;
        e_rd2      = 32'h0BAD_0000;
        e_ext      = b;
        e_instruc  = {28'hC0DE000, op};
        e_pc       = 32'h0000_4000;
        e_wra      = 5'd3;
    endtask

    task automatic idle();
        e_valid  = 1'b0;
        flush    = 1'b0;
        e_alu_op = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        checks++; if (em_valid !== 1'b0) begin errors++; $display("FAIL reset_em_valid: got %b want 0", em_valid); end
        checks++; if (em_alu_re !== '0) begin errors++; $display("FAIL reset_em_alu_re: got %h want 0", em_alu_re); end
        checks++; if (em_pc !== '0 || em_instruc !== '0) begin errors++; $display("FAIL reset_em_fields: got pc %h instr %h want 0", em_pc, em_instruc); end
        checks++; if (md_busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL reset_md: got busy %b stall %b want 0 0", md_busy, md_stall); end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        issue(4'd0, 32'd5, 32'd0);
        e_m_pass = 32'd7; e_w_wrd = 32'd9; e_rd2 = 32'd11;
        pass_src_a = 2'b01; pass_src_b = 2'b10; e_alu_src = 1'b0;
        e_pc = 32'h0000_0100; e_wra = 5'd17; e_instruc = 32'h0123_4567;
        step();
        checks++; if (em_alu_re !== 32'd16) begin errors++; $display("FAIL fwd_m_w_add: got %0d want 16", em_alu_re); end
        checks++; if (em_valid !== 1'b1 || em_wtdm !== 32'd9) begin errors++; $display("FAIL fwd_em_wtdm: got valid %b wtdm %0d want 1 9", em_valid, em_wtdm); end
        checks++; if (em_pc !== 32'h100 || em_wra !== 5'd17 || em_instruc !== 32'h0123_4567) begin errors++; $display("FAIL fwd_passthru: got pc %h wra %0d instr %h", em_pc, em_wra, em_instruc); end
        pass_src_a = 2'b11; pass_src_b = 2'b11;
        step();
        checks++; if (em_alu_re !== '0 || em_wtdm !== '0) begin errors++; $display("FAIL fwd_zero_sel: got re %h wtdm %h want 0 0", em_alu_re, em_wtdm); end
        pass_src_a = 2'b00; pass_src_b = 2'b01;
        step();
        checks++; if (em_alu_re !== 32'd12 || em_wtdm !== 32'd7) begin errors++; $display("FAIL fwd_rd1_m: got re %0d wtdm %0d want 12 7", em_alu_re, em_wtdm); end
        pass_src_b = 2'b10; e_alu_src = 1'b1; e_ext = 32'd100;
        step();
        checks++; if (em_alu_re !== 32'd105 || em_wtdm !== 32'd9) begin errors++; $display("FAIL fwd_imm_b: got re %0d wtdm %0d want 105 9", em_alu_re, em_wtdm); end
        idle();
    endtask

    task automatic test_alu_back_to_back();
        logic [3:0]  ops [11];
        logic [31:0] as  [11];
        logic [31:0] bs  [11];
        logic [31:0] exp [11];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6, 4'd7};
        as  = '{32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0, 32'd0, 32'd0, 32'hFF00_FF00, 32'hFFFF_0000,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1};
        bs  = '{32'd2, 32'd7, 32'h0000_0F00, 32'h0000_1234, 32'hABCD_1234, 32'h0FF0_0FF0, 32'h0F0F_0F0F,
                32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp = '{32'd1, 32'hFFFF_FFFE, 32'h0000_FFF0, 32'h1234_0000, 32'h1234_0000, 32'h0F00_0F00,
                32'hF0F0_0F0F, 32'd1, 32'd0, 32'd0, 32'd1};
        for (int i = 0; i < 11; i++) begin
            issue(ops[i], as[i], bs[i]);
            step();
            checks++;
            if (em_alu_re !== exp[i] || em_valid !== 1'b1) begin
                errors++;
                $display("FAIL alu_vec%0d op%0d: got %h valid %b want %h valid 1", i, ops[i], em_alu_re, em_valid, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_bubble();
        issue(4'd0, 32'd1, 32'd2);
        flush = 1'b1;
        step();
        checks++; if (em_valid !== 1'b0 || em_alu_re !== '0 || em_pc !== '0 || em_wra !== '0) begin errors++; $display("FAIL flush_bubble: got valid %b re %h pc %h wra %0d want all 0", em_valid, em_alu_re, em_pc, em_wra); end
        flush = 1'b0;
        step();
        checks++; if (em_valid !== 1'b1 || em_alu_re !== 32'd3) begin errors++; $display("FAIL after_flush: got valid %b re %0d want 1 3", em_valid, em_alu_re); end
        idle();
        step();
        checks++; if (em_valid !== 1'b0 || em_alu_re !== '0 || em_instruc !== '0) begin errors++; $display("FAIL invalid_bubble: got valid %b re %h instr %h want 0", em_valid, em_alu_re, em_instruc); end
    endtask

`ifdef MD_UNIT_EN
    task automatic md_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        issue(op, a, b);
        step();
        idle();
        repeat (lat) step();
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(4'd13, 32'd0, 32'd0);
        step();
        checks++; if (em_alu_re !== exp_lo || em_valid !== 1'b1) begin errors++; $display("FAIL %s_lo: got %h valid %b want %h", tag, em_alu_re, em_valid, exp_lo); end
        issue(4'd12, 32'd0, 32'd0);
        step();
        checks++; if (em_alu_re !== exp_hi || em_valid !== 1'b1) begin errors++; $display("FAIL %s_hi: got %h valid %b want %h", tag, em_alu_re, em_valid, exp_hi); end
        idle();
    endtask

    task automatic test_mult_stall();
        issue(4'd8, 32'hFFFF_FFFD, 32'd7);
        #1;
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL mult_issue_stall: got %b want 0", md_stall); end
        step();
        checks++; if (md_busy !== 1'b1 || em_valid !== 1'b1 || em_alu_re !== '0) begin errors++; $display("FAIL mult_start: got busy %b valid %b re %h want 1 1 0", md_busy, em_valid, em_alu_re); end
        issue(4'd13, 32'd0, 32'd0);
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            #1;
            checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL mflo_stall_c%0d: got %b want 1", i, md_stall); end
            step();
            checks++; if (em_valid !== 1'b0) begin errors++; $display("FAIL mflo_bubble_c%0d: got valid %b want 0", i, em_valid); end
        end
        checks++; if (md_busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL mult_done: got busy %b stall %b want 0 0", md_busy, md_stall); end
        step();
        checks++; if (em_alu_re !== 32'hFFFF_FFEB || em_valid !== 1'b1) begin errors++; $display("FAIL mflo_result: got %h valid %b want ffffffeb", em_alu_re, em_valid); end
        issue(4'd12, 32'd0, 32'd0);
        step();
        checks++; if (em_alu_re !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi_result: got %h want ffffffff", em_alu_re); end
        md_run(4'd9, 32'hFFFF_FFFF, 32'd2, MUL_LAT);
        read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        issue(4'd10, 32'd7, 32'd0);
        step();
        idle();
        repeat (DIV_LAT - 1) step();
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_last: got %b want 1", md_busy); end
        step();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_busy_end: got %b want 0", md_busy); end
        read_hilo("div0", 32'd7, 32'hFFFF_FFFF);
        md_run(4'd11, 32'd100, 32'd7, DIV_LAT);
        read_hilo("divu", 32'd2, 32'd14);
        md_run(4'd10, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_run(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
        read_hilo("div_ovf", 32'd0, 32'h8000_0000);
    endtask

    task automatic test_mthi_mtlo();
        issue(4'd14, 32'h0000_0055, 32'd0);
        step();
        checks++; if (em_alu_re !== 32'h55) begin errors++; $display("FAIL mthi_result: got %h want 55", em_alu_re); end
        issue(4'd15, 32'h0000_00AA, 32'd0);
        step();
        read_hilo("mt", 32'h55, 32'hAA);
    endtask

    task automatic test_flush_stall();
        issue(4'd8, 32'hFFFF_FFFE, 32'd3);
        step();
        issue(4'd12, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_c: got %b want 0", md_stall); end
        step();
        checks++; if (em_valid !== 1'b0 || md_busy !== 1'b1) begin errors++; $display("FAIL flush_during_md: got valid %b busy %b want 0 1", em_valid, md_busy); end
        idle();
        repeat (MUL_LAT - 1) step();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_md_done: got busy %b want 0", md_busy); end
        read_hilo("flush", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    endtask

    task automatic test_async_reset();
        issue(4'd10, 32'd100, 32'd7);
        step();
        checks++; if (em_valid !== 1'b1 || md_busy !== 1'b1) begin errors++; $display("FAIL pre_reset: got valid %b busy %b want 1 1", em_valid, md_busy); end
        idle();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (md_busy !== 1'b0 || em_valid !== 1'b0 || em_wtdm !== '0) begin errors++; $display("FAIL async_reset: got busy %b valid %b wtdm %h want 0", md_busy, em_valid, em_wtdm); end
        #1;
        reset = 1'b0;
        repeat (DIV_LAT + 1) step();
        read_hilo("post_reset", 32'd0, 32'd0);
    endtask
`else
    task automatic test_md_disabled();
        for (int op = 8; op < 16; op++) begin
            issue(4'(op), 32'd5, 32'd3);
            #1;
            checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL md_off_stall_op%0d: got %b want 0", op, md_stall); end
            step();
            checks++; if (em_alu_re !== '0 || em_valid !== 1'b1 || md_busy !== 1'b0) begin errors++; $display("FAIL md_off_op%0d: got re %h valid %b busy %b want 0 1 0", op, em_alu_re, em_valid, md_busy); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        issue(4'd0, 32'd1, 32'd2);
        step();
        checks++; if (em_valid !== 1'b1 || em_alu_re !== 32'd3) begin errors++; $display("FAIL pre_reset: got valid %b re %0d want 1 3", em_valid, em_alu_re); end
        idle();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (em_valid !== 1'b0 || em_alu_re !== '0 || em_pc !== '0) begin errors++; $display("FAIL async_reset: got valid %b re %h pc %h want 0", em_valid, em_alu_re, em_pc); end
        #1;
        reset = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_alu_back_to_back();
        test_bubble();
`ifdef MD_UNIT_EN
        test_mult_stall();
        test_mthi_mtlo();
        test_div();
        test_flush_stall();
`else
        test_md_disabled();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the five-stage pipeline, successor to the fixed 32-bit four-op execute stage. It sits between the ID/EX and EX/MEM boundaries. Its jobs:
- Selects forwarded operands.
- Computes a 16-op ALU result.
- Runs a multi-cycle multiply/divide unit with HI/LO registers.
- Registers the EX/MEM pipeline bundle, with bubble insertion for MD stalls and flushes.

## Interface
Parameters
- WIDTH, 32, datapath width (≥8).
- MUL_LAT, 5, multiply busy cycles (≥1).
- DIV_LAT, 10, divide busy cycles (≥1).

Ports
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- e_valid  in  1  E stage holds a live instruction.
- e_instruc  in  32  instruction word, passed through.
- e_alu_op  in  4  operation code (see Operation).
- e_alu_src  in  1  1: B = e_ext, else forwarded rt.
- e_rd1, e_rd2, e_ext, e_pc  in  WIDTH  rs value, rt value, extended immediate, PC.
- e_m_pass, e_w_wrd  in  WIDTH  forwarded M-stage and W-stage values.
- pass_src_a, pass_src_b  in  2  forward select: 00 rd1/rd2, 01 m_pass, 10 w_wrd, 11 zero.
- e_wra  in  5  destination register.
- flush  in  1  kill the E-stage instruction this cycle.
- md_stall  out  1  hazard unit must hold IF/ID/E this cycle.
- md_busy  out  1  MD unit computing.
- em_valid  out  1  EM bundle valid.
- em_instruc  out  32  registered instruction.
- em_alu_re, em_wtdm, em_pc  out  WIDTH  registered ALU result, store data (forwarded rt), PC.
- em_wra  out  5  registered destination.

## Operation
- A is selected by pass_src_a. rtf is selected by pass_src_b. B = e_alu_src ? e_ext : rtf.
- ALU ops, all results are WIDTH bits with wrap-around:
  - 0 ADD, 1 SUB, 2 OR, 3 LUI ({B[15:0], zeros} truncated to WIDTH), 4 AND, 5 XOR.
  - 6 SLT (signed A<B → 1 else 0), 7 SLTU.
  - 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO, 14 MTHI, 15 MTLO.
- Ops 8–11 result 0. Ops 14–15 result A.
- MD op = e_alu_op in 8..15.
- Stall rule: md_stall = e_valid & MD op & md_busy & !flush. Nothing else stalls.
- Accept = e_valid & !flush & !md_stall.
- Start: accept & op 8–11 latches a 2·WIDTH result and loads the counter with MUL_LAT or DIV_LAT.
- Multiply results: {HI,LO} = signed (op 8) or unsigned (op 9) A·B.
- Divide results: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
  - Divide by zero: LO = all ones, HI = A.
  - Signed MIN / −1: LO = MIN, HI = 0.
- MD FSM states are IDLE and BUSY.
  - IDLE → BUSY on start.
  - In BUSY the counter decrements each cycle. The pending result commits to HI/LO on the edge where the count goes 1→0, and the FSM returns to IDLE.
- MTHI/MTLO write A to HI/LO on the accepting edge.
- MFHI/MFLO return the current HI/LO.
- EM update each edge:
  - On accept: load all fields, em_valid = 1.
  - Otherwise (stall, flush, or !e_valid): bubble, with em_valid = 0 and all other em_* = 0.
- Flush has priority over stall. Flush never aborts an in-flight MD operation.

## Timing
- Reset (async): em_* = 0, em_valid = 0, HI = LO = 0, counter = 0, FSM IDLE, md_busy = 0, md_stall = 0.
- ALU latency is 1 cycle: the result is on em_alu_re after the accepting edge.
- MD start on edge t:
  - md_busy is high from after t until after edge t+LAT.
  - HI/LO hold the new values after edge t+LAT.
  - The first non-stalled MD op is accepted at edge t+LAT+1.
- md_stall and md_busy are combinational and sequential respectively. md_stall depends on the current inputs and md_busy.
- Reset mid-operation discards the pending result. HI/LO return to 0.

## Configuration
- MD_UNIT_EN defined: MD unit, HI/LO, counter and ops 8–15 behave as above.
- MD_UNIT_EN not defined:
  - Ops 8–15 produce result 0 with no side effects.
  - md_busy and md_stall are tied 0.
  - No HI/LO or MD logic is synthesised.

## Test plan
- Forwarding: rd1=5, m_pass=7, w_wrd=9; pass_src_a 01, pass_src_b 10, op ADD → em_alu_re = 16. Same with select 11 → 0 + 0.
- LUI/SLT: B=0x1234 → em_alu_re 0x12340000. SLT with A=−1, B=1 → 1; SLTU same operands → 0.
- MULT: A=−3, B=7, then MFLO issued next cycle.
  - MFLO stalled MUL_LAT cycles, with em_valid = 0 during the stall.
  - Then em_alu_re = −21 and MFHI gives 0xFFFFFFFF.
- DIV: A=7, B=0 → after DIV_LAT cycles LO = 0xFFFFFFFF, HI = 7. DIVU 100/7 → LO = 14, HI = 2.
- Flush during stall: flush asserted while MFHI is stalled → md_stall = 0, em_valid = 0, busy continues and HI is still updated.
- Async reset asserted mid-DIV → md_busy, em_valid, HI, LO are 0 immediately without a clock edge.
